register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file that answers the pipeline core's register traffic: two combinational read ports feed the decode stage, and one synchronous write port is driven by write-back.
- Holds 32 x 32-bit registers. $0 is hardwired to zero.
- Contains a slow scan engine that walks every register and shows its index and low value bits on the board's red LEDs for bring-up debug.

Parameters:
- SCAN_DIV, 50000000: clock cycles per LED scan step; must be >= 1; 1 means advance every cycle.
- DATA_WIDTH, 32: register width; only 32 is supported.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- register_file_read_address_1  input  6  read port 1 address; bit 5 must be 0
- register_file_read_address_2  input  6  read port 2 address; bit 5 must be 0
- register_file_write_address  input  6  write address from write-back
- register_file_write_value  input  32  write data
- register_file_write_enable  input  1  write strobe
- register_file_read_value_1  output  32  read data, port 1
- register_file_read_value_2  output  32  read data, port 2
- scan_hold  input  1  freezes the LED scan on the current register
- LEDR  output  18  debug display, registered

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset (asynchronous) clears:
  - all 32 registers to 0
  - scan divider count to 0
  - scan index to 0
  - LEDR to 18'h0
- Reset asserted mid-operation overrides any write in flight. The first write is accepted at the first posedge after reset deasserts.
- Write acceptance, at posedge clock, requires all of:
  - register_file_write_enable = 1
  - address[5] = 0
  - address[4:0] != 0
- A write with address[5] = 1 or to $0 is silently dropped; storage is unchanged.
- Read (combinational, zero latency): register_file_read_value_n = storage[address[4:0]].
  - Address 0 always returns 0.
  - address[5] = 1 returns 0.
- A write at edge N is visible on the read ports immediately after edge N (before N+1), subject to the Optional Feature.
- Both read ports may address the same register as each other and as the write port in the same cycle. Results must be independent and consistent.
- Scan engine is a two-state machine:
  - RUN: the divider counts 0..SCAN_DIV-1.
    - At the edge where count = SCAN_DIV-1: count -> 0 and scan index increments mod 32 (31 -> 0 wraps).
  - HOLD: entered while scan_hold = 1 at a posedge. Count is forced to 0 and the index is frozen. Return to RUN when scan_hold = 0; counting restarts from 0.
- LEDR, updated every posedge:
  - LEDR[17:13] = scan index value before this edge
  - LEDR[12:0] = storage[that index][12:0], sampled before this edge's write
  - A write to the displayed register at edge N therefore appears on LEDR after edge N+1.
  - Index 0 displays value bits 0.
- Arithmetic: the divider is a 32-bit unsigned counter; no other arithmetic.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: combinational write-to-read bypass. If the write-acceptance conditions hold and the write address equals a read address in the same cycle, that read port returns register_file_write_value in that cycle (before the edge).
  - Bypass never applies to $0 or to address[5] = 1.
- Undefined: the read port returns the stored (old) value until the edge. The core's own forwarding must cover that cycle.
- The LED path is unaffected in both cases.

Test Plan:
- Reset, then read addresses 0..31 on both ports -> all return 32'h0; LEDR = 18'h0.
- Write 32'hDEADBEEF to address 5; next cycle read port 1 = 5, port 2 = 5 -> both return 32'hDEADBEEF. Write 32'h1234 to address 0 -> read 0 returns 0.
- Same-cycle write of 32'hCAFEF00D to address 7 with read port 1 = 7:
  - REGFILE_WRITE_BYPASS_EN defined -> 32'hCAFEF00D in that cycle.
  - Undefined -> old value, then 32'hCAFEF00D after the edge.
- Write to address 6'h25 with enable = 1 -> storage of address 5 unchanged; read 6'h25 returns 0.
- SCAN_DIV = 3, register 1 = 32'h1FFF, register 2 = 32'h0ABC:
  - LEDR index advances every 3 cycles.
  - While index = 1, LEDR = {5'd1, 13'h1FFF}; while index = 2, LEDR = {5'd2, 13'h0ABC}.
  - Index wraps 31 -> 0.
  - scan_hold = 1 for 10 cycles -> index frozen; count restarts from 0 on release.
- Assert reset asynchronously between edges while registers hold nonzero values and a write is pending -> outputs and storage are 0 immediately with no clock edge; the pending write is not committed.

Source files
------------

// File: rtl/register_file_if.sv
// Register-traffic bus between the pipeline core (master) and the register file (slave).
interface register_file_if;
  logic [5:0]  register_file_read_address_1;
  logic [5:0]  register_file_read_address_2;
  logic [5:0]  register_file_write_address;
  logic [31:0] register_file_write_value;
  logic        register_file_write_enable;
  logic [31:0] register_file_read_value_1;
  logic [31:0] register_file_read_value_2;

  modport master (
    output register_file_read_address_1,
    output register_file_read_address_2,
    output register_file_write_address,
    output register_file_write_value,
    output register_file_write_enable,
    input  register_file_read_value_1,
    input  register_file_read_value_2
  );

  modport slave (
    input  register_file_read_address_1,
    input  register_file_read_address_2,
    input  register_file_write_address,
    input  register_file_write_value,
    input  register_file_write_enable,
    output register_file_read_value_1,
    output register_file_read_value_2
  );
endinterface

// File: rtl/register_file.sv
// 32x32 register file ($0 hardwired to zero), two async read ports, one sync write port,
// plus a slow LED scan of register contents. REGFILE_WRITE_BYPASS_EN enables write-to-read bypass.
module register_file #(
  parameter int unsigned SCAN_DIV   = 50000000,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  register_file_if.slave  rf,
  input  logic            scan_hold,
  output logic [17:0]     LEDR
);

  typedef enum logic {RUN, HOLD} scan_state_t;

  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

  logic [DATA_WIDTH-1:0] storage [32];
  logic                  write_accept;
  scan_state_t           scan_state;
  logic [31:0]           scan_count;
  logic [4:0]            scan_index;

  assign write_accept = rf.register_file_write_enable
                     && !rf.register_file_write_address[5]
                     && (rf.register_file_write_address[4:0] != 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) storage[i] <= '0;
    end else if (write_accept) begin
      storage[rf.register_file_write_address[4:0]] <= rf.register_file_write_value;
    end
  end

  always_comb begin
    rf.register_file_read_value_1 = '0;
    if (!rf.register_file_read_address_1[5] && (rf.register_file_read_address_1[4:0] != 5'd0))
      rf.register_file_read_value_1 = storage[rf.register_file_read_address_1[4:0]];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (write_accept && (rf.register_file_write_address == rf.register_file_read_address_1))
      rf.register_file_read_value_1 = rf.register_file_write_value;
`endif
  end

  always_comb begin
    rf.register_file_read_value_2 = '0;
    if (!rf.register_file_read_address_2[5] && (rf.register_file_read_address_2[4:0] != 5'd0))
      rf.register_file_read_value_2 = storage[rf.register_file_read_address_2[4:0]];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (write_accept && (rf.register_file_write_address == rf.register_file_read_address_2))
      rf.register_file_read_value_2 = rf.register_file_write_value;
`endif
  end

  // LEDR samples the pre-edge index and storage, so a write shows one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_state <= RUN;
      scan_count <= '0;
      scan_index <= '0;
      LEDR       <= '0;
    end else begin
      LEDR <= {scan_index, (scan_index == 5'd0) ? 13'h0 : storage[scan_index][12:0]};
      case (scan_state)
        RUN: begin
          if (scan_hold) begin
            scan_state <= HOLD;
            scan_count <= '0;
          end else if (scan_count == SCAN_LAST) begin
            scan_count <= '0;
            scan_index <= scan_index + 5'd1;
          end else begin
            scan_count <= scan_count + 32'd1;
          end
        end
        HOLD: begin
          scan_count <= '0;
          if (!scan_hold) scan_state <= RUN;
        end
        default: begin
          scan_state <= RUN;
          scan_count <= '0;
        end
      endcase
    end
  end

endmodule
